// File: rtl/fifo_pkg.sv
// Shared types and helpers for the asynchronous FIFO write-side logic.
package fifo_pkg;

  // Occupancy of the write-side skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam int STALL_CNT_W = 16;
  localparam int GRAY_MAX_W  = 32;

  // Gray-to-binary conversion for a code of width w (1..GRAY_MAX_W).
  // Bits at or above w are masked off, so callers can pass a zero-extended
  // pointer and cast the result back down to the pointer width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int                    w
  );
    logic [GRAY_MAX_W-1:0] mask;
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    if (w >= GRAY_MAX_W) mask = '1;
    else                 mask = (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
    gm = g & mask;
    b  = '0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry skid buffer between the producer handshake and the FIFO write port.
// Handshake: a word moves on the producer side when s_valid && s_ready at a
// rising edge, and into the FIFO when wr_en && !full at a rising edge. s_ready
// and wr_en are decodes of the registered next state, so neither depends
// combinationally on s_valid or full. The output register always holds the
// oldest buffered word; the skid register holds the second one.
module wr_skid_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  input  logic              full,
  output logic              wr_en,
  output logic [DWIDTH-1:0] wr_data,
  output skid_state_e       state_o
);

  skid_state_e       state_q, state_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              wr_en_q, wr_en_d;
  logic              s_ready_q, s_ready_d;

  logic accept;
  logic drain;

  assign accept = s_valid && s_ready_q;
  assign drain  = wr_en_q && !full;

  // Next-state, data steering and registered output decodes.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = s_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_d = s_data;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = s_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    wr_en_d   = (state_d != ST_EMPTY);
    s_ready_d = (state_d != ST_TWO);
  end

  // State machine registers; reset drops any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      wr_en_q   <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      wr_en_q   <= wr_en_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign wr_en   = wr_en_q;
  assign wr_data = out_q;
  assign state_o = state_q;

endmodule

// File: rtl/wr_front.sv
// Write-side front end of the asynchronous FIFO: producer skid buffer,
// registered fill level / almost_full from the pointers, and a saturating
// producer stall counter.
module wr_front
  import fifo_pkg::*;
#(
  parameter int SIZE      = 3,
  parameter int DWIDTH    = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst,
  input  logic                   s_valid,
  input  logic [DWIDTH-1:0]      s_data,
  output logic                   s_ready,
  input  logic                   full,
  input  logic [SIZE:0]          bi_wr_ptr,
  input  logic [SIZE:0]          gr_rd_ptr,
  output logic                   wr_en,
  output logic [DWIDTH-1:0]      wr_data,
  output logic [SIZE:0]          wr_level,
  output logic                   almost_full,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [SIZE:0] AF_TH = (SIZE + 1)'(AF_THRESH);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  skid_state_e skid_state;

  wr_skid_buf #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk     (wr_clk),
    .rst     (wr_rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .full    (full),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .state_o (skid_state)
  );

  logic [SIZE:0]            rd_bin;
  logic [SIZE:0]            wr_level_q, wr_level_d;
  logic                     almost_full_q, almost_full_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Occupancy from pointers; modulo-2^(SIZE+1) subtraction absorbs wrap.
  // A stale read pointer only makes this larger, never smaller.
  always_comb begin
    rd_bin        = (SIZE + 1)'(gray2bin(GRAY_MAX_W'(gr_rd_ptr), SIZE + 1));
    wr_level_d    = bi_wr_ptr - rd_bin;
    almost_full_d = (wr_level_d >= AF_TH);
  end

  // Stall = producer offering a word while the buffer is full (state TWO,
  // which is exactly when s_ready is low).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s_valid && (skid_state == ST_TWO) && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Level, flag and stall counter registers.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_level_q    <= '0;
      almost_full_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      wr_level_q    <= wr_level_d;
      almost_full_q <= almost_full_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign wr_level    = wr_level_q;
  assign almost_full = almost_full_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_wr_front.sv
// Directed bench for wr_front: handshake streaming, full back-pressure,
// pointer-derived level, reset discard and stall counter saturation.
module tb_wr_front;

  localparam int SIZE   = 3;
  localparam int DWIDTH = 8;

  logic              wr_clk;
  logic              wr_rst;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic              full;
  logic [SIZE:0]     bi_wr_ptr;
  logic [SIZE:0]     gr_rd_ptr;
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic [SIZE:0]     wr_level;
  logic              almost_full;
  logic [15:0]       stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DWIDTH-1:0] exp_q[$];
  logic [DWIDTH-1:0] got_q[$];

  wr_front #(
    .SIZE      (SIZE),
    .DWIDTH    (DWIDTH),
    .AF_THRESH (6)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .full        (full),
    .bi_wr_ptr   (bi_wr_ptr),
    .gr_rd_ptr   (gr_rd_ptr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_level    (wr_level),
    .almost_full (almost_full),
    .stall_cnt   (stall_cnt)
  );

  // clock / reset
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // write monitor: capture every word the FIFO would store
  always @(posedge wr_clk) begin
    if (!wr_rst && wr_en && !full) got_q.push_back(wr_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst  = 1'b1;
    s_valid = 1'b0;
    step();
    wr_rst  = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    wr_rst    = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    full      = 1'b0;
    bi_wr_ptr = '0;
    gr_rd_ptr = '0;
    #2;

    // ---- reset state
    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_wr_data", wr_data, 0);
    check("rst_level", wr_level, 0);
    check("rst_af", almost_full, 0);
    check("rst_stall", stall_cnt, 0);

    // ---- stream 0x01..0x10 with full=0
    full    = 1'b0;
    s_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_data = DWIDTH'(k);
      exp_q.push_back(DWIDTH'(k));
      step();
      check($sformatf("strm_wr_en%0d", k), wr_en, 1);
      check($sformatf("strm_data%0d", k), wr_data, k);
      check($sformatf("strm_ready%0d", k), s_ready, 1);
    end
    s_valid = 1'b0;
    step();
    check("strm_idle_wr_en", wr_en, 0);
    compare_writes("strm");
    check("strm_stall", stall_cnt, 0);

    // ---- back-pressure with full=1
    do_reset();
    full    = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA1;
    step();
    check("bp_ready1", s_ready, 1);
    check("bp_data1", wr_data, 8'hA1);
    s_data = 8'hA2;
    step();
    check("bp_ready2", s_ready, 0);
    check("bp_data2", wr_data, 8'hA1);
    s_data = 8'hA3;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_data%0d", k), wr_data, 8'hA1);
      check($sformatf("bp_hold_wr_en%0d", k), wr_en, 1);
      check($sformatf("bp_hold_ready%0d", k), s_ready, 0);
    end
    check("bp_stall3", stall_cnt, 3);
    check("bp_no_write", got_q.size(), 0);
    full = 1'b0;
    step();
    check("bp_rel_data", wr_data, 8'hA2);
    check("bp_rel_ready", s_ready, 1);
    step();
    check("bp_a3_data", wr_data, 8'hA3);
    s_valid = 1'b0;
    step();
    check("bp_empty", wr_en, 0);
    check("bp_stall_total", stall_cnt, 4);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    compare_writes("bp");

    // ---- level / almost_full
    bi_wr_ptr = 4'b0001;
    gr_rd_ptr = 4'b1000;
    step();
    check("lvl_wrap", wr_level, 2);
    check("lvl_wrap_af", almost_full, 0);
    bi_wr_ptr = 4'd6;
    gr_rd_ptr = 4'd0;
    #1;
    check("lvl_lag", wr_level, 2);
    step();
    check("lvl6", wr_level, 6);
    check("lvl6_af", almost_full, 1);
    bi_wr_ptr = 4'd8;
    step();
    check("lvl8", wr_level, 8);
    check("lvl8_af", almost_full, 1);
    bi_wr_ptr = 4'd7;
    gr_rd_ptr = 4'b0011;
    step();
    check("lvl5", wr_level, 5);
    check("lvl5_af", almost_full, 0);

    // ---- reset while in TWO with full=1
    do_reset();
    bi_wr_ptr = 4'd3;
    gr_rd_ptr = 4'd0;
    full      = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'hB1;
    step();
    s_data = 8'hB2;
    step();
    step();
    check("mid_stall", stall_cnt, 1);
    check("mid_level", wr_level, 3);
    wr_rst  = 1'b1;
    s_valid = 1'b0;
    step();
    wr_rst = 1'b0;
    check("mid_wr_en", wr_en, 0);
    check("mid_ready", s_ready, 1);
    check("mid_data", wr_data, 0);
    check("mid_stall_clr", stall_cnt, 0);
    check("mid_level_clr", wr_level, 0);
    full = 1'b0;
    got_q.delete();
    for (int k = 0; k < 4; k++) step();
    check("mid_no_stale", got_q.size(), 0);
    check("mid_idle_wr_en", wr_en, 0);

    // ---- stall counter saturation
    do_reset();
    full    = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    for (int k = 0; k < 65537; k++) step();
    check("sat_near", stall_cnt, 16'hFFFF);
    for (int k = 0; k < 70000 - 65537; k++) step();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_data", wr_data, 8'h5A);
    check("sat_no_write", got_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
